// File: rtl/paddle_ctrl.sv
// paddle_ctrl: frame-synchronous paddle Y controller with debounced buttons and clamped motion
// ports: i_CLK/i_RST_N clock and async active-low reset; i_vSync active-low frame sync;
//        i_btn_up/i_btn_down raw buttons; i_enable run gate; i_recenter centre pulse;
//        o_rect_y_pos paddle top Y; o_frame_tick one pulse per frame; o_moving last tick moved
module paddle_ctrl #(
  parameter int HEIGHT   = 100,
  parameter int SCREEN_H = 480,
  parameter int SPEED    = 4,
  parameter int DEBOUNCE = 250000
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_vSync,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_enable,
  input  logic       i_recenter,
  output logic [9:0] o_rect_y_pos,
  output logic       o_frame_tick,
  output logic       o_moving
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [9:0] CENTER = 10'((SCREEN_H - HEIGHT) / 2);
  localparam logic [9:0] MAX_Y = 10'(SCREEN_H - HEIGHT);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);
  typedef enum logic [1:0] {S_HOLD, S_RUN, S_CENTER} state_t;
  state_t state, state_nxt;
  logic [1:0] up_s, dn_s, vs_s;
  logic vs_prev, up_db, dn_db, tick, mv_nxt;
  logic [CW-1:0] up_cnt, dn_cnt;
  logic [9:0] step, y_nxt;
  logic [10:0] sum;
  assign tick = vs_prev & ~vs_s[1];
  assign sum = {1'b0, o_rect_y_pos} + 11'(SPEED);
  always_comb begin
    step = (up_db & ~dn_db) ? (o_rect_y_pos >= 10'(SPEED) ? o_rect_y_pos - 10'(SPEED) : '0)
         : (dn_db & ~up_db) ? (sum > {1'b0, MAX_Y} ? MAX_Y : sum[9:0])
         : o_rect_y_pos;
    state_nxt = i_recenter ? S_CENTER : i_enable ? S_RUN : S_HOLD;
    y_nxt = o_rect_y_pos;
    mv_nxt = o_moving;
    if (state == S_CENTER) begin
      y_nxt = CENTER;
      mv_nxt = 1'b0;
    end else if (state == S_RUN && !i_recenter) begin
      if (tick) begin
        y_nxt = step;
        mv_nxt = step != o_rect_y_pos;
      end
      if (!i_enable) mv_nxt = 1'b0;
    end
  end
  always_ff @(posedge i_CLK or negedge i_RST_N)
    if (!i_RST_N) state <= S_HOLD;
    else state <= state_nxt;
  // vSync sync resets high so reset release never looks like a falling edge
  always_ff @(posedge i_CLK or negedge i_RST_N)
    if (!i_RST_N) begin
      up_s <= '0;
      dn_s <= '0;
      vs_s <= 2'b11;
      vs_prev <= 1'b1;
      up_db <= 1'b0;
      dn_db <= 1'b0;
      up_cnt <= '0;
      dn_cnt <= '0;
      o_rect_y_pos <= CENTER;
      o_frame_tick <= 1'b0;
      o_moving <= 1'b0;
    end else begin
      up_s <= {up_s[0], i_btn_up};
      dn_s <= {dn_s[0], i_btn_down};
      vs_s <= {vs_s[0], i_vSync};
      vs_prev <= vs_s[1];
      up_cnt <= (up_s[1] == up_db || up_cnt == LAST) ? '0 : up_cnt + CW'(1);
      dn_cnt <= (dn_s[1] == dn_db || dn_cnt == LAST) ? '0 : dn_cnt + CW'(1);
      up_db <= up_db ^ (up_s[1] != up_db && up_cnt == LAST);
      dn_db <= dn_db ^ (dn_s[1] != dn_db && dn_cnt == LAST);
      o_rect_y_pos <= y_nxt;
      o_frame_tick <= tick;
      o_moving <= mv_nxt;
    end
endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed bench with a cycle model of the paddle controller and literal pins
module tb_paddle_ctrl;
  localparam int D = 4, SP = 4, HT = 100, SH = 480, MAXY = SH - HT, CEN = MAXY / 2;
  logic clk = 0, rst_n = 0, vs = 1, up = 0, dn = 0, en = 0, rc = 0;
  logic [9:0] y;
  logic ft, mv;
  int checks = 0, errors = 0, nticks = 0, ymax = 0, nt0 = 0;
  bit saw_mv = 0, chk_on = 0;
  bit h_up[0:7], h_dn[0:7], h_vs[0:7];
  int my = CEN, ms = 0;
  bit mft = 0, mmv = 0, dbu = 0, dbd = 0;
  paddle_ctrl #(.HEIGHT(HT), .SCREEN_H(SH), .SPEED(SP), .DEBOUNCE(D)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_vSync(vs), .i_btn_up(up), .i_btn_down(dn),
    .i_enable(en), .i_recenter(rc), .o_rect_y_pos(y), .o_frame_tick(ft), .o_moving(mv)
  );
  always #5 clk = ~clk;
  // model: h_*[j] holds the raw input seen j edges ago; synced value is 2 edges old,
  // a debounced level flips once the last D synced samples all disagree with it
  initial forever begin
    bit tick, su, sd;
    int n;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int j = 0; j < 8; j++) begin
        h_up[j] = 0;
        h_dn[j] = 0;
        h_vs[j] = 1;
      end
      my = CEN; ms = 0; mft = 0; mmv = 0; dbu = 0; dbd = 0;
    end else begin
      for (int j = 7; j > 0; j--) begin
        h_up[j] = h_up[j-1];
        h_dn[j] = h_dn[j-1];
        h_vs[j] = h_vs[j-1];
      end
      h_up[0] = up; h_dn[0] = dn; h_vs[0] = vs;
      tick = h_vs[3] && !h_vs[2];
      mft = tick;
      if (ms == 2) begin
        my = CEN;
        mmv = 0;
      end else if (ms == 1 && !rc) begin
        if (tick) begin
          n = (dbu && !dbd) ? ((my - SP < 0) ? 0 : my - SP)
            : (dbd && !dbu) ? ((my + SP > MAXY) ? MAXY : my + SP) : my;
          mmv = (n != my);
          my = n;
        end
        if (!en) mmv = 0;
      end
      ms = rc ? 2 : en ? 1 : 0;
      su = 1; sd = 1;
      for (int j = 2; j <= D + 1; j++) begin
        if (h_up[j] == dbu) su = 0;
        if (h_dn[j] == dbd) sd = 0;
      end
      if (su) dbu = !dbu;
      if (sd) dbd = !dbd;
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (ft) nticks++;
      if (mv) saw_mv = 1;
      if (int'(y) > ymax) ymax = int'(y);
      if (chk_on) begin
        checks++;
        if (int'(y) != my || ft !== mft || mv !== mmv) begin
          errors++;
          $display("FAIL cycle_model t=%0t y/tick/moving got %0d/%0b/%0b expected %0d/%0b/%0b",
                   $time, y, ft, mv, my, mft, mmv);
        end
      end
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic frame();
    vs = 0;
    repeat (2) @(negedge clk);
    vs = 1;
    repeat (6) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_y", y, CEN); chk("rst_tick", ft, 0); chk("rst_moving", mv, 0);
    rst_n = 1; en = 1; chk_on = 1;
    repeat (4) @(negedge clk);
    chk("no_tick_on_release", nticks, 0);
    vs = 0;
    @(negedge clk); chk("tick_edge1", ft, 0);
    @(negedge clk); chk("tick_edge2", ft, 0); vs = 1;
    @(negedge clk); chk("tick_edge3", ft, 1);
    @(negedge clk); chk("tick_edge4", ft, 0);
    nt0 = nticks;
    repeat (3) frame();
    chk("ticks_per_frame", nticks - nt0, 3); chk("idle_y", y, CEN);
    up = 1;
    repeat (2) frame();
    chk("up_first_step", y, 186); chk("up_moving", mv, 1);
    repeat (58) frame();
    chk("up_clamp", y, 0); chk("up_clamp_moving", mv, 0); chk("saw_moving", saw_mv, 1);
    up = 0; dn = 1;
    repeat (2) frame();
    chk("down_first_step", y, 4);
    repeat (98) frame();
    chk("down_clamp", y, MAXY); chk("down_clamp_moving", mv, 0); chk("down_max", ymax, MAXY);
    dn = 0;
    repeat (2) frame();
    up = 1;
    repeat (3) @(negedge clk);
    up = 0;
    repeat (3) frame();
    chk("glitch_y", y, MAXY); chk("glitch_moving", mv, 0);
    up = 1; dn = 1;
    repeat (3) frame();
    chk("both_y", y, MAXY); chk("both_moving", mv, 0);
    up = 0;
    repeat (2) frame();
    rc = 1;
    @(negedge clk); rc = 0; chk("recenter_n1", y, MAXY);
    @(negedge clk); chk("recenter_n2", y, CEN);
    vs = 0;
    @(negedge clk);
    @(negedge clk); rc = 1; vs = 1;
    @(negedge clk); rc = 0; chk("rc_tick_y", y, CEN); chk("rc_tick_pulse", ft, 1);
    @(negedge clk); chk("rc_tick_y4", y, CEN);
    @(negedge clk); chk("rc_tick_y5", y, CEN); chk("rc_tick_moving", mv, 0);
    frame();
    chk("run_after_rc", y, CEN + SP); chk("run_after_rc_moving", mv, 1);
    en = 0;
    @(negedge clk); chk("disable_clears_moving", mv, 0);
    dn = 0; up = 1;
    repeat (4) frame();
    chk("frozen_y", y, CEN + SP); chk("frozen_moving", mv, 0);
    en = 1;
    repeat (2) frame();
    chk("resume_y", y, CEN - SP); chk("resume_moving", mv, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1 chk("midrst_y", y, CEN); chk("midrst_tick", ft, 0); chk("midrst_moving", mv, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
